// File: rtl/div_unit.sv
// Iterative restoring DIV/DIVU: quotient -> LO, remainder -> HI. Optional macro: DIV_EARLY_OUT_EN.
// Latency WIDTH+1 cycles from start (divide-by-zero 2; early-out 1 when the macro is defined).
// No queueing: start is only sampled in IDLE, so EX holds its stall while busy is high.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             annul,
    input  logic             signed_en,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVZERO,
        S_ON,
        S_END
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH:0]   part_q, part_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               sgn_q, sgn_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;

    logic               neg_a_in, neg_b_in;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in;
    logic [2*WIDTH:0]   shifted, step_res;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   q_fix, r_fix;
    logic               step_unused;

    assign neg_a_in = signed_en & dividend[WIDTH-1];
    assign neg_b_in = signed_en & divisor[WIDTH-1];
    assign mag_a_in = neg_a_in ? -dividend : dividend;
    assign mag_b_in = neg_b_in ? -divisor : divisor;

    // One restoring step; a borrow in trial's top bit means the subtraction is undone.
    assign shifted  = part_q << 1;
    assign trial    = shifted[2*WIDTH:WIDTH] - {1'b0, dvsr_q};
    assign step_res = trial[WIDTH] ? shifted : {trial, shifted[WIDTH-1:1], 1'b1};

    // The restored upper part is always below the divisor, so its top bit is zero.
    assign step_unused = step_res[2*WIDTH];

    assign q_fix = (sgn_q & (neg_a_q ^ neg_b_q)) ? -step_res[WIDTH-1:0] : step_res[WIDTH-1:0];
    assign r_fix = (sgn_q & neg_a_q) ? -step_res[2*WIDTH-1:WIDTH] : step_res[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        dvsr_d  = dvsr_q;
        sgn_d   = sgn_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start && !annul) begin
                    sgn_d   = signed_en;
                    neg_a_d = neg_a_in;
                    neg_b_d = neg_b_in;
                    dvsr_d  = mag_b_in;
                    part_d  = {{(WIDTH+1){1'b0}}, mag_a_in};
                    cnt_d   = '0;
                    if (divisor == '0) begin
                        state_d = S_DIVZERO;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (mag_a_in < mag_b_in) begin
                        state_d = S_END;
                        quot_d  = '0;
                        rem_d   = dividend;
                        dbz_d   = 1'b0;
                    end
`endif
                    else begin
                        state_d = S_ON;
                    end
                end
            end
            S_DIVZERO: begin
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_END;
                    quot_d  = '0;
                    rem_d   = '0;
                    dbz_d   = 1'b1;
                end
            end
            S_ON: begin
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    part_d = step_res;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_END;
                        quot_d  = q_fix;
                        rem_d   = r_fix;
                        dbz_d   = 1'b0;
                    end
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            part_q  <= '0;
            dvsr_q  <= '0;
            sgn_q   <= 1'b0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            dvsr_q  <= dvsr_d;
            sgn_q   <= sgn_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign ready       = (state_q == S_END);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at start, compared on ready.
module tb_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         annul = 1'b0;
    logic         signed_en = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, ready, div_by_zero;
    logic [W-1:0] quotient, remainder;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .annul(annul),
        .signed_en(signed_en), .dividend(dividend), .divisor(divisor),
        .busy(busy), .ready(ready), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           rdy_cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         got;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    logic         last_dbz = 1'b0;

    function automatic void model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dbz, output int lat);
        logic signed [W-1:0] sa, sbv;
        logic [W-1:0]        ma, mb;
        sa  = a;
        sbv = b;
        ma  = (sgn && a[W-1]) ? -a : a;
        mb  = (sgn && b[W-1]) ? -b : b;
        dbz = 1'b0;
        lat = W;
        if (b == '0) begin
            q = '0; r = '0; dbz = 1'b1; lat = 1;
        end else if (!sgn) begin
            q = a / b; r = a % b;
        end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            q = a; r = '0;
        end else begin
            q = sa / sbv; r = sa % sbv;
        end
`ifdef DIV_EARLY_OUT_EN
        if (b != '0 && ma < mb) lat = 0;
`else
        if (ma == mb) lat = W;
`endif
    endfunction

    // Scoreboard consumer: every ready must match the oldest outstanding request.
    always @(negedge clk) begin
        if (reset) begin
            if (sb.size() > 0) check("busy_during_op", busy, 1);
            if (ready) begin
                if (sb.size() == 0) begin
                    check("spurious_ready", 1, 0);
                end else begin
                    got = sb.pop_front();
                    check("quotient", quotient, got.q);
                    check("remainder", remainder, got.r);
                    check("div_by_zero", div_by_zero, got.dbz);
                    check("ready_cycle", cyc, got.rdy_cyc);
                    last_q   = got.q;
                    last_r   = got.r;
                    last_dbz = got.dbz;
                end
            end
        end
    end

    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   lat;
        @(negedge clk);
        #1;
        start     = 1'b1;
        signed_en = sgn;
        dividend  = a;
        divisor   = b;
        model(sgn, a, b, e.q, e.r, e.dbz, lat);
        e.rdy_cyc = cyc + 1 + lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start     = 1'b0;
        signed_en = $urandom_range(0, 1);
        dividend  = $urandom;
        divisor   = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (sb.size() > 0) begin
            check("timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(sgn, a, b);
        wait_done();
    endtask

    task automatic raw_start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        #1;
        start = 1'b1; signed_en = 1'b0; dividend = a; divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        reset = 1'b1;

        run(1'b0, 32'd100, 32'd7);
        @(negedge clk);
        check("busy_after_end", busy, 0);
        run(1'b1, 32'hFFFF_FFF9, 32'd2);
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run(1'b0, 32'd5, 32'd0);
        run(1'b1, 32'd5, 32'd0);
        run(1'b0, 32'd3, 32'd10);
        run(1'b1, 32'hFFFF_FF9C, 32'd7);
        run(1'b0, 32'd100, 32'd7);

        // Flush mid-ON: no ready, outputs keep the previous result.
        raw_start(32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        #1 annul = 1'b1;
        @(posedge clk);
        #1 annul = 1'b0;
        @(negedge clk);
        check("annul_busy", busy, 0);
        check("annul_quotient", quotient, last_q);
        check("annul_remainder", remainder, last_r);
        check("annul_dbz", div_by_zero, last_dbz);
        run(1'b0, 32'd9, 32'd3);

        // annul beats start in IDLE.
        @(negedge clk);
        #1 start = 1'b1; annul = 1'b1; dividend = 32'd8; divisor = 32'd2;
        @(posedge clk);
        #1 start = 1'b0; annul = 1'b0;
        @(negedge clk);
        check("annul_idle_busy", busy, 0);

        // Asynchronous reset in the middle of an iteration.
        raw_start(32'd1000, 32'd7);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ready", ready, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_dbz", div_by_zero, 0);
        @(negedge clk);
        reset = 1'b1;
        run(1'b0, 32'd1000, 32'd7);

        // start pulses while busy must be ignored.
        issue(1'b0, 32'd100000, 32'd13);
        repeat (5) @(negedge clk);
        #1 start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);
        check("no_queue_busy", busy, 0);

        for (int i = 0; i < 12; i++) begin
            logic [W-1:0] b;
            case (i % 4)
                0: b = $urandom;
                1: b = $urandom_range(1, 20);
                2: b = -$urandom_range(1, 20);
                default: b = '0;
            endcase
            run(1'(i % 2), $urandom, b);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Parametrised iterative integer divider for the EX stage. It replaces single-cycle ALU-only arithmetic with a multi-cycle DIV/DIVU engine. It produces quotient (to LO) and remainder (to HI) one bit per cycle via restoring division, and uses a start/ready handshake so EX can hold its stall request while `busy` is high. It sits beside the ALU in EX; its results feed the existing HI/LO write path.

## Interface
- `WIDTH`, 32: operand/result width in bits (≥ 4).
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width.

- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request a division; sampled only in IDLE.
- `annul` input 1: abort the in-flight division (pipeline flush).
- `signed_en` input 1: 1 = signed (DIV), 0 = unsigned (DIVU); captured with `start`.
- `dividend` input WIDTH: captured with `start`.
- `divisor` input WIDTH: captured with `start`.
- `busy` output 1: state ≠ IDLE.
- `ready` output 1: one-cycle result-valid strobe (state == END).
- `quotient` output WIDTH: registered quotient (LO).
- `remainder` output WIDTH: registered remainder (HI).
- `div_by_zero` output 1: registered; set with a result whose divisor was 0.

## Operation
- States: IDLE, DIVZERO, ON, END. Encoding is free; the FSM is registered.
- IDLE: `start`=1 and `annul`=0 →
  - capture `signed_en`, operand signs, and operand magnitudes (absolute values when signed);
  - clear the counter;
  - go to DIVZERO if divisor == 0, else ON.
- DIVZERO: next edge → END, with quotient = 0, remainder = 0, `div_by_zero` = 1.
- ON: each edge performs one restoring step on a (2·WIDTH+1)-bit partial register:
  - shift left 1;
  - trial-subtract the divisor magnitude from the upper WIDTH+1 bits;
  - if the result is non-negative, keep it and shift in quotient bit 1, else shift in 0;
  - counter++.
- ON → END on the edge where the counter reaches WIDTH−1. On that edge, register the sign-corrected results:
  - quotient negated if the operand signs differ (signed only);
  - remainder negated if the dividend is negative (signed only);
  - `div_by_zero` = 0.
- END: lasts exactly one cycle, then IDLE. Outputs hold until the next result is registered.
- Signed arithmetic (MIPS semantics): quotient truncates toward zero; remainder takes the dividend's sign. Most-negative ÷ −1 gives quotient = most-negative (two's-complement wrap), remainder = 0, no flag.
- `annul`=1 in DIVZERO/ON/END: next edge → IDLE, no `ready`, outputs unchanged. `annul` wins over `start` in IDLE.
- `start` while busy: ignored; no queueing.
- Reset (asynchronous, any state, mid-operation included): state = IDLE, counter = 0, all outputs 0.

## Timing
- Edge 0: `start` sampled.
- Normal path: `ready` is high in the cycle after edge WIDTH. Latency is WIDTH+1 cycles from `start`; 33 cycles for WIDTH=32.
- Divide-by-zero: `ready` is high in the cycle after edge 1.
- `busy` rises after edge 0 and falls after the edge that leaves END.
- Back-to-back: `start` may be asserted during the `ready` cycle; it is sampled in IDLE, one cycle after END.
- Throughput: one division per WIDTH+2 cycles.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - In IDLE, if divisor ≠ 0 and the dividend magnitude < the divisor magnitude, go directly to END.
  - Result: quotient 0, remainder = original dividend.
  - `ready` is high in the cycle after edge 0.
- `DIV_EARLY_OUT_EN` undefined: every nonzero-divisor operation takes the full WIDTH iterations.

## Test plan
- Unsigned 100 ÷ 7, WIDTH=32 → quotient 14, remainder 2, `ready` high exactly 33 cycles after `start`, `busy` high throughout.
- Signed −7 ÷ 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 0x80000000 ÷ 0xFFFFFFFF → quotient 0x80000000, remainder 0, `div_by_zero` 0.
- 5 ÷ 0 (both modes) → `ready` in the cycle after edge 1, quotient 0, remainder 0, `div_by_zero` 1. The next valid division clears the flag.
- `annul` at cycle 10 of an ON sequence → IDLE next edge, no `ready` ever, outputs keep prior values. An immediately following 9 ÷ 3 returns 3 r 0 on schedule.
- Reset deasserted-low mid-ON → all outputs 0 and `busy` 0 immediately. A `start` after release completes normally. `start` pulses while busy are ignored.
- With `DIV_EARLY_OUT_EN`: unsigned 3 ÷ 10 → quotient 0, remainder 3, `ready` in the cycle after edge 0. Without the macro: same result at 33 cycles.
